// File: rtl/song_sequencer.sv
// Song-selection and playback sequencer: debounced next/prev/play buttons, wrap/saturate
// song index, load/enable/idle engine handshake, auto-advance and BCD display digits.
// Optional hold-to-repeat on next/prev is enabled by defining HOLD_REPEAT_EN.
module song_sequencer #(
  parameter int unsigned NUM_SONGS       = 8,
  parameter int unsigned SONG_W          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter int unsigned WRAP            = 1,
  parameter int unsigned AUTO_ADVANCE    = 1,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              btn_play,
  input  logic              song_done,
  input  logic              engine_idle,
  output logic [SONG_W-1:0] song_number,
  output logic              load_pulse,
  output logic              play_en,
  output logic              busy,
  output logic [3:0]        bcd_tens,
  output logic [3:0]        bcd_ones
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SONG_W-1:0] LAST_IDX = SONG_W'(NUM_SONGS - 1);

  if (NUM_SONGS < 2 || NUM_SONGS > 99 || (64'd1 << SONG_W) < 64'(NUM_SONGS) ||
      DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("song_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_LOADING,
    ST_PLAYING,
    ST_DRAINING
  } state_t;

  // Button bit order: 0 = next, 1 = prev, 2 = play
  logic [2:0]      btn_raw;
  logic [2:0]      sync1, sync2, deb, ev;
  logic [DB_W-1:0] db_cnt [3];
  logic [2:0]      flip_c, rise_c, rpt_fire_c;

  assign btn_raw = {btn_play, btn_prev, btn_next};

  always_comb begin
    flip_c = '0;
    rise_c = '0;
    for (int i = 0; i < 3; i++) begin
      flip_c[i] = (sync2[i] != deb[i]) && (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1));
      rise_c[i] = flip_c[i] && sync2[i];
    end
  end

  // Synchroniser, debounce counters and one-cycle button events
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      ev    <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      ev    <= rise_c | rpt_fire_c;
      for (int i = 0; i < 3; i++) begin
        if (flip_c[i]) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else if (sync2[i] != deb[i]) begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

`ifdef HOLD_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES + 1);
  logic [RPT_W-1:0] rpt_cnt [2];

  always_comb begin
    rpt_fire_c = '0;
    for (int i = 0; i < 2; i++)
      rpt_fire_c[i] = deb[i] && (rpt_cnt[i] == RPT_W'(REPEAT_CYCLES - 1));
  end

  // Hold-repeat counters run while the debounced level is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        rpt_cnt[i] <= (!deb[i] || rpt_fire_c[i]) ? '0 : rpt_cnt[i] + RPT_W'(1);
    end
  end
`else
  assign rpt_fire_c = '0;
`endif

  state_t            state_q, state_n;
  logic              restart_q, restart_n;
  logic [SONG_W-1:0] idx_n, inc_idx, dec_idx, nav_idx;
  logic              nav_next, nav_prev, can_inc, can_dec, nav_change;
  logic [6:0]        bcd_val;
  logic [3:0]        tens_c, ones_c;

  // Next-state, restart flag and index update
  always_comb begin
    state_n    = state_q;
    restart_n  = restart_q;
    idx_n      = song_number;
    nav_next   = ev[0] & ~ev[1];
    nav_prev   = ev[1] & ~ev[0];
    inc_idx    = (song_number == LAST_IDX) ? '0 : song_number + SONG_W'(1);
    dec_idx    = (song_number == '0) ? LAST_IDX : song_number - SONG_W'(1);
    can_inc    = (WRAP != 0) || (song_number != LAST_IDX);
    can_dec    = (WRAP != 0) || (song_number != '0);
    nav_change = (nav_next && can_inc) || (nav_prev && can_dec);
    nav_idx    = nav_next ? inc_idx : dec_idx;

    case (state_q)
      ST_STOPPED: begin
        if (ev[2]) state_n = ST_LOADING;
        else if (nav_change) idx_n = nav_idx;
      end
      ST_LOADING: state_n = ST_PLAYING;
      ST_PLAYING: begin
        if (ev[2]) begin
          restart_n = 1'b0;
          state_n   = ST_DRAINING;
        end else if (nav_change) begin
          idx_n     = nav_idx;
          restart_n = 1'b1;
          state_n   = ST_DRAINING;
        end else if (song_done) begin
          if ((AUTO_ADVANCE != 0) && can_inc) begin
            idx_n     = inc_idx;
            restart_n = 1'b1;
          end else begin
            restart_n = 1'b0;
          end
          state_n = ST_DRAINING;
        end
      end
      ST_DRAINING: begin
        if (ev[2]) restart_n = ~restart_q;
        if (nav_change) idx_n = nav_idx;
        if (engine_idle) state_n = restart_n ? ST_LOADING : ST_STOPPED;
      end
      default: state_n = ST_STOPPED;
    endcase
  end

  // Display digits of song_number+1 by comparing against multiples of ten
  always_comb begin
    bcd_val = 7'(song_number) + 7'd1;
    tens_c  = '0;
    ones_c  = 4'(bcd_val);
    for (int t = 1; t < 10; t++) begin
      if (bcd_val >= 7'(10 * t)) begin
        tens_c = 4'(t);
        ones_c = 4'(bcd_val - 7'(10 * t));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_STOPPED;
      restart_q   <= 1'b0;
      song_number <= '0;
      load_pulse  <= 1'b0;
      play_en     <= 1'b0;
      busy        <= 1'b0;
      bcd_tens    <= 4'd0;
      bcd_ones    <= 4'd1;
    end else begin
      state_q     <= state_n;
      restart_q   <= restart_n;
      song_number <= idx_n;
      load_pulse  <= (state_n == ST_LOADING);
      play_en     <= (state_n == ST_PLAYING);
      busy        <= (state_n == ST_LOADING) || (state_n == ST_DRAINING);
      bcd_tens    <= tens_c;
      bcd_ones    <= ones_c;
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: a wrapping and a saturating instance share one set of inputs
// and are compared against a press-level behavioural model.
module tb_song_sequencer;

  localparam int unsigned N  = 3;
  localparam int unsigned SW = 4;

  logic clk, reset, btn_next, btn_prev, btn_play, song_done, engine_idle;
  logic [SW-1:0] song_w, song_s;
  logic load_w, play_w, busy_w, load_s, play_s, busy_s;
  logic [3:0] tens_w, ones_w, tens_s, ones_s;

  int vectors, miscompares;
  int loads_w, loads_s, busy_cyc_s, changes_w;
  logic [SW-1:0] load_song_w, last_song_w;

  // Press-level model state
  int idx_w, idx_s;
  bit pw, ps;

  song_sequencer #(.NUM_SONGS(N), .SONG_W(SW), .DEBOUNCE_CYCLES(4), .WRAP(1),
                   .AUTO_ADVANCE(1), .REPEAT_CYCLES(20)) u_wrap (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev), .btn_play(btn_play),
    .song_done(song_done), .engine_idle(engine_idle), .song_number(song_w),
    .load_pulse(load_w), .play_en(play_w), .busy(busy_w), .bcd_tens(tens_w), .bcd_ones(ones_w));

  song_sequencer #(.NUM_SONGS(N), .SONG_W(SW), .DEBOUNCE_CYCLES(4), .WRAP(0),
                   .AUTO_ADVANCE(1), .REPEAT_CYCLES(20)) u_sat (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev), .btn_play(btn_play),
    .song_done(song_done), .engine_idle(engine_idle), .song_number(song_s),
    .load_pulse(load_s), .play_en(play_s), .busy(busy_s), .bcd_tens(tens_s), .bcd_ones(ones_s));

  always #5 clk = ~clk;

  // Event monitors sampled away from the active edge
  always @(negedge clk) begin
    if (load_w) begin
      loads_w = loads_w + 1;
      load_song_w = song_w;
    end
    if (load_s) loads_s = loads_s + 1;
    if (busy_s) busy_cyc_s = busy_cyc_s + 1;
    if (song_w !== last_song_w) changes_w = changes_w + 1;
    last_song_w = song_w;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn_next = 1'b0; btn_prev = 1'b0; btn_play = 1'b0;
    song_done = 1'b0; engine_idle = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    idx_w = 0; idx_s = 0; pw = 1'b0; ps = 1'b0;
  endtask

  task automatic press(input bit n, input bit p, input bit pl, input int hold);
    btn_next = n; btn_prev = p; btn_play = pl;
    tick(hold);
    btn_next = 1'b0; btn_prev = 1'b0; btn_play = 1'b0;
    tick(12);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_next = 1'b0; btn_prev = 1'b0; btn_play = 1'b0;
    song_done = 1'b0; engine_idle = 1'b1;
    #2;
    vectors++; if (song_w !== 4'd0) begin miscompares++; $display("FAIL reset_song got %0d want 0", song_w); end
    vectors++; if (load_w !== 1'b0) begin miscompares++; $display("FAIL reset_load got %b want 0", load_w); end
    vectors++; if (play_w !== 1'b0) begin miscompares++; $display("FAIL reset_play got %b want 0", play_w); end
    vectors++; if (busy_w !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_w); end
    vectors++; if (tens_w !== 4'd0) begin miscompares++; $display("FAIL reset_tens got %0d want 0", tens_w); end
    vectors++; if (ones_w !== 4'd1) begin miscompares++; $display("FAIL reset_ones got %0d want 1", ones_w); end
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_debounce();
    int waited;
    do_reset();
    btn_next = 1'b1; tick(3); btn_next = 1'b0; tick(12);
    vectors++; if (song_w !== 4'd0) begin miscompares++; $display("FAIL glitch_song got %0d want 0", song_w); end
    btn_next = 1'b1;
    waited = 0;
    while (song_w === 4'd0 && waited < 20) begin tick(1); waited++; end
    vectors++; if (waited >= 20) begin miscompares++; $display("FAIL debounce_timeout waited %0d want <20", waited); end
    vectors++; if (song_w !== 4'd1) begin miscompares++; $display("FAIL debounce_song got %0d want 1", song_w); end
    vectors++; if (ones_w !== 4'd1) begin miscompares++; $display("FAIL bcd_lag got %0d want 1", ones_w); end
    tick(1);
    vectors++; if (ones_w !== 4'd2) begin miscompares++; $display("FAIL bcd_ones got %0d want 2", ones_w); end
    vectors++; if (tens_w !== 4'd0) begin miscompares++; $display("FAIL bcd_tens got %0d want 0", tens_w); end
    btn_next = 1'b0; tick(12);
  endtask

  task automatic test_wrap();
    int exp_w[4] = '{1, 2, 0, 2};
    int exp_s[4] = '{1, 2, 2, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(i < 3, i == 3, 1'b0, 6);
      vectors++; if (song_w !== SW'(exp_w[i])) begin miscompares++; $display("FAIL wrap_step%0d got %0d want %0d", i, song_w, exp_w[i]); end
      vectors++; if (song_s !== SW'(exp_s[i])) begin miscompares++; $display("FAIL sat_step%0d got %0d want %0d", i, song_s, exp_s[i]); end
    end
  endtask

  task automatic test_sat_no_transition();
    int lw0, ls0, bs0;
    do_reset();
    press(1'b0, 1'b0, 1'b1, 6);
    lw0 = loads_w; ls0 = loads_s; bs0 = busy_cyc_s;
    press(1'b0, 1'b1, 1'b0, 6);
    vectors++; if (song_w !== 4'd2) begin miscompares++; $display("FAIL satplay_wrap_song got %0d want 2", song_w); end
    vectors++; if (loads_w - lw0 !== 1) begin miscompares++; $display("FAIL satplay_wrap_loads got %0d want 1", loads_w - lw0); end
    vectors++; if (song_s !== 4'd0) begin miscompares++; $display("FAIL satplay_song got %0d want 0", song_s); end
    vectors++; if (loads_s - ls0 !== 0) begin miscompares++; $display("FAIL satplay_loads got %0d want 0", loads_s - ls0); end
    vectors++; if (busy_cyc_s - bs0 !== 0) begin miscompares++; $display("FAIL satplay_busy got %0d want 0", busy_cyc_s - bs0); end
    vectors++; if (play_s !== 1'b1) begin miscompares++; $display("FAIL satplay_play got %b want 1", play_s); end
  endtask

  task automatic test_play();
    int lw0;
    do_reset();
    lw0 = loads_w;
    press(1'b0, 1'b0, 1'b1, 6);
    vectors++; if (loads_w - lw0 !== 1) begin miscompares++; $display("FAIL play_loads got %0d want 1", loads_w - lw0); end
    vectors++; if (load_song_w !== 4'd0) begin miscompares++; $display("FAIL play_load_song got %0d want 0", load_song_w); end
    vectors++; if (play_w !== 1'b1) begin miscompares++; $display("FAIL play_en got %b want 1", play_w); end
    engine_idle = 1'b0;
    press(1'b0, 1'b0, 1'b1, 6);
    vectors++; if (play_w !== 1'b0) begin miscompares++; $display("FAIL stop_play got %b want 0", play_w); end
    vectors++; if (busy_w !== 1'b1) begin miscompares++; $display("FAIL stop_drain_busy got %b want 1", busy_w); end
    engine_idle = 1'b1;
    tick(3);
    vectors++; if (busy_w !== 1'b0) begin miscompares++; $display("FAIL stop_busy got %b want 0", busy_w); end
    vectors++; if (play_w !== 1'b0) begin miscompares++; $display("FAIL stop_final_play got %b want 0", play_w); end
    vectors++; if (loads_w - lw0 !== 1) begin miscompares++; $display("FAIL stop_loads got %0d want 1", loads_w - lw0); end
  endtask

  task automatic test_auto_advance();
    int lw0, ls0;
    do_reset();
    press(1'b1, 1'b0, 1'b0, 6);
    press(1'b1, 1'b0, 1'b0, 6);
    press(1'b0, 1'b0, 1'b1, 6);
    engine_idle = 1'b0;
    song_done = 1'b1; tick(1); song_done = 1'b0; tick(1);
    vectors++; if (play_w !== 1'b0) begin miscompares++; $display("FAIL adv_play got %b want 0", play_w); end
    vectors++; if (song_w !== 4'd0) begin miscompares++; $display("FAIL adv_song got %0d want 0", song_w); end
    vectors++; if (song_s !== 4'd2) begin miscompares++; $display("FAIL adv_sat_song got %0d want 2", song_s); end
    lw0 = loads_w; ls0 = loads_s;
    tick(10);
    vectors++; if (loads_w - lw0 !== 0) begin miscompares++; $display("FAIL adv_early_load got %0d want 0", loads_w - lw0); end
    vectors++; if (busy_w !== 1'b1) begin miscompares++; $display("FAIL adv_wait_busy got %b want 1", busy_w); end
    engine_idle = 1'b1;
    tick(6);
    vectors++; if (loads_w - lw0 !== 1) begin miscompares++; $display("FAIL adv_loads got %0d want 1", loads_w - lw0); end
    vectors++; if (load_song_w !== 4'd0) begin miscompares++; $display("FAIL adv_load_song got %0d want 0", load_song_w); end
    vectors++; if (play_w !== 1'b1) begin miscompares++; $display("FAIL adv_replay got %b want 1", play_w); end
    vectors++; if (play_s !== 1'b0) begin miscompares++; $display("FAIL adv_sat_play got %b want 0", play_s); end
    vectors++; if (busy_s !== 1'b0) begin miscompares++; $display("FAIL adv_sat_busy got %b want 0", busy_s); end
    vectors++; if (loads_s - ls0 !== 0) begin miscompares++; $display("FAIL adv_sat_loads got %0d want 0", loads_s - ls0); end
  endtask

  task automatic test_conflict();
    do_reset();
    press(1'b1, 1'b1, 1'b0, 6);
    vectors++; if (song_w !== 4'd0) begin miscompares++; $display("FAIL conflict_wrap got %0d want 0", song_w); end
    vectors++; if (song_s !== 4'd0) begin miscompares++; $display("FAIL conflict_sat got %0d want 0", song_s); end
    vectors++; if (busy_w !== 1'b0) begin miscompares++; $display("FAIL conflict_busy got %b want 0", busy_w); end
  endtask

  task automatic test_reset_drain();
    int lw0;
    do_reset();
    press(1'b1, 1'b0, 1'b0, 6);
    press(1'b0, 1'b0, 1'b1, 6);
    engine_idle = 1'b0;
    press(1'b0, 1'b0, 1'b1, 6);
    vectors++; if (busy_w !== 1'b1) begin miscompares++; $display("FAIL drain_busy got %b want 1", busy_w); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (song_w !== 4'd0) begin miscompares++; $display("FAIL rstdrain_song got %0d want 0", song_w); end
    vectors++; if (busy_w !== 1'b0) begin miscompares++; $display("FAIL rstdrain_busy got %b want 0", busy_w); end
    vectors++; if (play_w !== 1'b0) begin miscompares++; $display("FAIL rstdrain_play got %b want 0", play_w); end
    vectors++; if (ones_w !== 4'd1) begin miscompares++; $display("FAIL rstdrain_ones got %0d want 1", ones_w); end
    vectors++; if (load_w !== 1'b0) begin miscompares++; $display("FAIL rstdrain_load got %b want 0", load_w); end
    tick(2);
    reset = 1'b0;
    lw0 = loads_w;
    tick(3);
    engine_idle = 1'b1;
    tick(5);
    vectors++; if (busy_w !== 1'b0) begin miscompares++; $display("FAIL postrst_busy got %b want 0", busy_w); end
    vectors++; if (play_w !== 1'b0) begin miscompares++; $display("FAIL postrst_play got %b want 0", play_w); end
    vectors++; if (loads_w - lw0 !== 0) begin miscompares++; $display("FAIL postrst_loads got %0d want 0", loads_w - lw0); end
  endtask

  task automatic test_hold();
    int c0, waited, exp_changes;
`ifdef HOLD_REPEAT_EN
    exp_changes = 3;
`else
    exp_changes = 1;
`endif
    do_reset();
    c0 = changes_w;
    btn_next = 1'b1;
    waited = 0;
    while (song_w === 4'd0 && waited < 20) begin tick(1); waited++; end
    vectors++; if (waited >= 20) begin miscompares++; $display("FAIL hold_timeout waited %0d want <20", waited); end
    tick(45);
    btn_next = 1'b0;
    tick(20);
    vectors++; if (changes_w - c0 !== exp_changes) begin miscompares++; $display("FAIL hold_advances got %0d want %0d", changes_w - c0, exp_changes); end
  endtask

  task automatic test_random();
    int op, lw0, ls0, exp_lw, exp_ls;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 3));
      lw0 = loads_w; ls0 = loads_s;
      exp_lw = 0; exp_ls = 0;
      case (op)
        0: begin
          press(1'b1, 1'b0, 1'b0, int'($urandom_range(6, 10)));
          idx_w = (idx_w + 1) % N; if (pw) exp_lw = 1;
          if (idx_s < N - 1) begin idx_s++; if (ps) exp_ls = 1; end
        end
        1: begin
          press(1'b0, 1'b1, 1'b0, int'($urandom_range(6, 10)));
          idx_w = (idx_w + N - 1) % N; if (pw) exp_lw = 1;
          if (idx_s > 0) begin idx_s--; if (ps) exp_ls = 1; end
        end
        2: begin
          press(1'b0, 1'b0, 1'b1, int'($urandom_range(6, 10)));
          if (!pw) exp_lw = 1;
          if (!ps) exp_ls = 1;
          pw = !pw; ps = !ps;
        end
        default: begin
          song_done = 1'b1; tick(1); song_done = 1'b0; tick(8);
          if (pw) begin idx_w = (idx_w + 1) % N; exp_lw = 1; end
          if (ps) begin
            if (idx_s < N - 1) begin idx_s++; exp_ls = 1; end
            else ps = 1'b0;
          end
        end
      endcase
      vectors++; if (song_w !== SW'(idx_w)) begin miscompares++; $display("FAIL rnd%0d op%0d song_w got %0d want %0d", it, op, song_w, idx_w); end
      vectors++; if (song_s !== SW'(idx_s)) begin miscompares++; $display("FAIL rnd%0d op%0d song_s got %0d want %0d", it, op, song_s, idx_s); end
      vectors++; if (play_w !== pw) begin miscompares++; $display("FAIL rnd%0d op%0d play_w got %b want %b", it, op, play_w, pw); end
      vectors++; if (play_s !== ps) begin miscompares++; $display("FAIL rnd%0d op%0d play_s got %b want %b", it, op, play_s, ps); end
      vectors++; if (ones_w !== 4'((idx_w + 1) % 10) || tens_w !== 4'((idx_w + 1) / 10)) begin miscompares++; $display("FAIL rnd%0d bcd got %0d%0d want %0d", it, tens_w, ones_w, idx_w + 1); end
      vectors++; if (loads_w - lw0 !== exp_lw) begin miscompares++; $display("FAIL rnd%0d op%0d loads_w got %0d want %0d", it, op, loads_w - lw0, exp_lw); end
      vectors++; if (loads_s - ls0 !== exp_ls) begin miscompares++; $display("FAIL rnd%0d op%0d loads_s got %0d want %0d", it, op, loads_s - ls0, exp_ls); end
    end
  endtask

  initial begin
    clk = 1'b0;
    vectors = 0; miscompares = 0;
    loads_w = 0; loads_s = 0; busy_cyc_s = 0; changes_w = 0;
    load_song_w = '0; last_song_w = '0;
    idx_w = 0; idx_s = 0; pw = 1'b0; ps = 1'b0;
    test_reset();
    test_debounce();
    test_wrap();
    test_sat_no_transition();
    test_play();
    test_auto_advance();
    test_conflict();
    test_reset_drain();
    test_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
